rr_merge_stage: RTL

- Round-robin N:1 merge stage that sits directly upstream of the single-channel pipeline register stage and feeds its valide_in/Datain/ready handshake.
- Accepts up to ch_num independent valid/ready request streams and grants one per cycle.
- Registers the winning beat plus its source index into one output slot.
- Output slot uses the same handshake as the downstream stage: a beat transfers when valide_out && ready_in.

---
 rtl/pipeline_pkg.sv | 19 +
 rtl/rr_merge_if.sv | 39 +++
 rtl/rr_merge_stage_rr_pick.sv | 46 ++++
 rtl/rr_merge_stage.sv | 102 ++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// pipeline_pkg: constants and helpers shared by the merge stage, its
// rotating-priority finder and its handshake interface.
package pipeline_pkg;

    // Default data width per channel and default channel count.
    localparam int DEF_BUS_WIDTH = 8;
    localparam int DEF_CH_NUM    = 4;

    // Width of a channel index. Never narrower than one bit.
    function automatic int id_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Packed-data convention: channel ch occupies bits [lane_lo(ch, w) +: w].
    function automatic int lane_lo(input int ch, input int width);
        return ch * width;
    endfunction

endpackage

// File: rtl/rr_merge_if.sv
// rr_merge_if: request side (ch_num valid/ready streams) and output slot side
// of the round-robin merge stage. The slave modport is the merge stage view.
// Optional macro ARB_LAST_EN adds the per-channel last_in and the registered
// last_out used for packet locking.
interface rr_merge_if #(
    parameter int bus_width = pipeline_pkg::DEF_BUS_WIDTH,
    parameter int ch_num    = pipeline_pkg::DEF_CH_NUM,
    localparam int id_width = pipeline_pkg::id_w(ch_num)
);
    logic [ch_num-1:0]           valide_in;
    logic [ch_num*bus_width-1:0] Datain;
    logic [ch_num-1:0]           ready_out;
    logic                        valide_out;
    logic [bus_width-1:0]        Dataout;
    logic [id_width-1:0]         grant_id;
    logic                        ready_in;
`ifdef ARB_LAST_EN
    logic [ch_num-1:0]           last_in;
    logic                        last_out;
`endif

    modport slave (
        input  valide_in, Datain, ready_in,
`ifdef ARB_LAST_EN
        input  last_in,
        output last_out,
`endif
        output ready_out, valide_out, Dataout, grant_id
    );

    modport master (
        output valide_in, Datain, ready_in,
`ifdef ARB_LAST_EN
        output last_in,
        input  last_out,
`endif
        input  ready_out, valide_out, Dataout, grant_id
    );
endinterface

// File: rtl/rr_merge_stage_rr_pick.sv
// rr_pick: combinational rotating-priority finder. Returns the first
// requester at or after ptr, wrapping modulo ch_num, as one-hot and index.
// Built as a find-first over the request vector duplicated side by side,
// with lower-copy positions below ptr masked out.
module rr_pick import pipeline_pkg::*; #(
    parameter int ch_num    = DEF_CH_NUM,
    localparam int id_width = id_w(ch_num)
) (
    input  logic [ch_num-1:0]   req,
    input  logic [id_width-1:0] ptr,
    output logic [ch_num-1:0]   gnt,
    output logic [id_width-1:0] gnt_id,
    output logic                any
);
    logic [2*ch_num-1:0] dbl;
    logic [2*ch_num-1:0] masked;
    logic [id_width:0]   first;

    assign dbl = {req, req};
    assign any = |req;

    // Drop lower-copy requesters that sit before ptr; the upper copy covers the wrap.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        masked = dbl;
        for (int j = 0; j < ch_num; j++) begin
            if (j < int'(ptr)) masked[j] = 1'b0;
        end
    end

    // Lowest set bit of the masked double vector wins.
    always_comb begin
        first = '0;
        for (int j = 2*ch_num-1; j >= 0; j--) begin
            if (masked[j]) first = j[id_width:0];
        end
    end

    // Fold the double-width position back to a channel index and one-hot grant.
    always_comb begin
        if (int'(first) >= ch_num) gnt_id = id_width'(int'(first) - ch_num);
        else                       gnt_id = first[id_width-1:0];
        gnt = '0;
        if (any) gnt[gnt_id] = 1'b1;
    end
endmodule

// File: rtl/rr_merge_stage.sv
// rr_merge_stage: round-robin N:1 merge into one registered output slot with
// valid/ready handshake on both sides. A beat loads when the slot is empty or
// draining, so full throughput needs no bubble.
// Optional macro ARB_LAST_EN: a beat without last locks arbitration to its
// channel until that channel's last beat loads, so packets never interleave.
module rr_merge_stage import pipeline_pkg::*; #(
    parameter int bus_width = DEF_BUS_WIDTH,
    parameter int ch_num    = DEF_CH_NUM,
    localparam int id_width = id_w(ch_num)
) (
    input logic       clk,
    input logic       rst,
    rr_merge_if.slave bus
);
    logic [id_width-1:0]  ptr;
    logic [ch_num-1:0]    req;
    logic [ch_num-1:0]    gnt;
    logic [id_width-1:0]  gnt_id;
    logic                 any;
    logic                 load_en;
    logic [bus_width-1:0] sel_data;
    logic [id_width-1:0]  ptr_after;
`ifdef ARB_LAST_EN
    logic                 lock;
    logic                 sel_last;
`endif

    assign load_en = !bus.valide_out || bus.ready_in;

`ifdef ARB_LAST_EN
    // While a packet is open only its owner (held in ptr) may compete.
    always_comb begin
        req = bus.valide_in;
        if (lock) begin
            req      = '0;
            req[ptr] = bus.valide_in[ptr];
        end
    end
`else
    assign req = bus.valide_in;
`endif

    rr_pick #(.ch_num(ch_num)) u_pick (
        .req    (req),
        .ptr    (ptr),
        .gnt    (gnt),
        .gnt_id (gnt_id),
        .any    (any)
    );

    // Accept is offered only to the winner, only when the slot can load, never in reset.
    assign bus.ready_out = (rst && load_en) ? gnt : '0;

    // Pointer moves just past the winner, wrapping to channel 0.
    assign ptr_after = (int'(gnt_id) == ch_num - 1) ? '0 : gnt_id + 1'b1;

    // One-hot mux of the winning channel's data (and last flag).
    always_comb begin
        sel_data = '0;
`ifdef ARB_LAST_EN
        sel_last = 1'b0;
`endif
        for (int i = 0; i < ch_num; i++) begin
            if (gnt[i]) begin
                sel_data = bus.Datain[lane_lo(i, bus_width) +: bus_width];
`ifdef ARB_LAST_EN
                sel_last = bus.last_in[i];
`endif
            end
        end
    end

    // Output slot and arbitration pointer: load on grant, empty when idle, hold on stall.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.valide_out <= 1'b0;
            bus.Dataout    <= '0;
            bus.grant_id   <= '0;
            ptr            <= '0;
`ifdef ARB_LAST_EN
            bus.last_out   <= 1'b0;
            lock           <= 1'b0;
`endif
        end else if (load_en) begin
            if (any) begin
                // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
                bus.valide_out <= 1'b1;
                bus.Dataout    <= sel_data;
                bus.grant_id   <= gnt_id;
`ifdef ARB_LAST_EN
                bus.last_out   <= sel_last;
                lock           <= !sel_last;
                ptr            <= sel_last ? ptr_after : gnt_id;
`else
                ptr            <= ptr_after;
`endif
            end else begin
                bus.valide_out <= 1'b0;
            end
        end
    end
endmodule
